bcd_conversion_scheduler: RTL

- Shares one binary_to_bcd_transcoder instance among NUM_REQ requesters.
- Round-robin arbitration selects one requester at a time.
- Holds the selected operand on the transcoder input for SETTLE_CYCLES, captures the BCD result, and returns it with the requester index over a valid/ready response port.
- Sits between display/report clients and the single transcoder datapath.

---
 rtl/bcd_conversion_scheduler_pkg.sv | 24 ++
 rtl/bcd_conversion_scheduler_rr_arbiter.sv | 48 ++++
 rtl/bcd_conversion_scheduler.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/bcd_conversion_scheduler_pkg.sv
// Shared state encodings and BCD sizing helpers for the conversion scheduler.
// The digit-count function matches the one used by the binary_to_bcd_transcoder.
package bcd_conversion_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } sched_state_e;

    // Decimal digits needed for a w-bit binary value (1233/4096 ~ log10(2)).
    function automatic int unsigned bcd_digits(input int unsigned w);
        return ((w * 1233) >> 12) + 1;
    endfunction

    function automatic int unsigned bcd_width(input int unsigned w);
        return 4 * bcd_digits(w);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bcd_conversion_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first set request at or after ptr_i, wrapping.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter
    import bcd_conversion_scheduler_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]              req_i,
    input  logic [idx_width(N)-1:0]   ptr_i,
    input  logic                      enable_i,
    output logic [N-1:0]              grant_c,
    output logic [idx_width(N)-1:0]   idx_c
);

    localparam int unsigned IDX_W = idx_width(N);

    int   hi_sel;
    int   lo_sel;
    int   sel;
    logic hi_hit;
    logic lo_hit;

    // Descending scan so the last hit is the lowest index in each half.
    always_comb begin
        hi_sel  = 0;
        lo_sel  = 0;
        hi_hit  = 1'b0;
        lo_hit  = 1'b0;
        for (int j = int'(N) - 1; j >= 0; j--) begin
            if (req_i[j]) begin
                lo_hit = 1'b1;
                lo_sel = j;
                if (j >= int'(ptr_i)) begin
                    hi_hit = 1'b1;
                    hi_sel = j;
                end
            end
        end
        sel     = hi_hit ? hi_sel : lo_sel;
        grant_c = '0;
        idx_c   = '0;
        if (enable_i && (hi_hit || lo_hit)) begin
            grant_c = N'(1) << sel;
            idx_c   = IDX_W'(sel);
        end
    end

endmodule

// File: rtl/bcd_conversion_scheduler.sv
// Time-shares one external binary-to-BCD transcoder among NUM_REQ requesters.
// Optional macro BCD_SCHED_STABLE_CHECK_EN adds the rsp_unstable output.
module bcd_conversion_scheduler
    import bcd_conversion_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned SETTLE_CYCLES = 20
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]          req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [WIDTH-1:0]                  xc_in,
    input  logic [bcd_width(WIDTH)-1:0]       xc_out,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [bcd_width(WIDTH)-1:0]       rsp_data,
    output logic [idx_width(NUM_REQ)-1:0]     rsp_id,
    output logic                              busy
`ifdef BCD_SCHED_STABLE_CHECK_EN
    ,
    output logic                              rsp_unstable
`endif
);

    localparam int unsigned OUT_WIDTH = bcd_width(WIDTH);
    localparam int unsigned ID_W      = idx_width(NUM_REQ);
    localparam int unsigned CNT_W     = (SETTLE_CYCLES <= 1) ? 1 : $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

    sched_state_e          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [WIDTH-1:0]      xc_in_q, xc_in_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [OUT_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic                  busy_q, busy_d;

    logic [NUM_REQ-1:0]    grant_c;
    logic [ID_W-1:0]       gidx_c;
    logic [WIDTH-1:0]      sel_data_c;
    logic                  capture_c;

    // Reset gates the grant so req_ready reads 0 while reset_n is low.
    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req_i    (req_valid),
        .ptr_i    (ptr_q),
        .enable_i ((state_q == ST_IDLE) && reset_n),
        .grant_c  (grant_c),
        .idx_c    (gidx_c)
    );

    assign req_ready = grant_c;
    assign capture_c = (state_q == ST_SETTLE) && (cnt_q == '0);

    // One-hot operand mux.
    always_comb begin
        sel_data_c = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (grant_c[k]) begin
                sel_data_c = req_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        xc_in_d     = xc_in_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            ST_IDLE: begin
                if (|grant_c) begin
                    xc_in_d  = sel_data_c;
                    rsp_id_d = gidx_c;
                    cnt_d    = CNT_LOAD;
                    ptr_d    = (gidx_c == LAST_ID) ? '0 : gidx_c + ID_W'(1);
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (capture_c) begin
                    rsp_data_d  = xc_out;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            xc_in_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            xc_in_q     <= xc_in_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            busy_q      <= busy_d;
        end
    end

    assign xc_in     = xc_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = busy_q;

`ifdef BCD_SCHED_STABLE_CHECK_EN
    logic [OUT_WIDTH-1:0] xc_prev_q;
    logic                 unstable_q, unstable_d;

    // Previous-cycle xc_out, tracked from the grant cycle through SETTLE.
    always_comb begin
        unstable_d = unstable_q;
        if (capture_c) begin
            unstable_d = (xc_out != xc_prev_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xc_prev_q  <= '0;
            unstable_q <= 1'b0;
        end else begin
            if (state_q != ST_RESP) begin
                xc_prev_q <= xc_out;
            end
            unstable_q <= unstable_d;
        end
    end

    assign rsp_unstable = unstable_q;
`endif

endmodule
